pe_array_ctrl: RTL and testbench

Instruction dispatcher for the next-generation PE array. It decouples the instruction stream from PE availability with an instruction FIFO and real `ins_ready` backpressure. It tracks a per-PE busy state from `start`/`done` and supports single-PE or `GRP_SIZE`-PE group issue. It also adds barrier instructions and sticky error flags. It sits between the instruction decoder and the PE groups, and drives each PE's `start` and its shared instruction fields.

---
 rtl/pe_array_ctrl_pkg.sv | 37 +++
 rtl/pe_array_ctrl_fifo.sv | 83 ++++++++
 rtl/pe_array_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pe_array_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pe_array_ctrl_pkg
// Shared definitions for the PE array instruction dispatcher:
//   - bw(): bit width needed to encode n distinct values (global helper)
//   - instruction word layout: field LSBs, widths and single-bit flags
//   - head disposition enum used by the dispatcher
// ---------------------------------------------------------------------------
package pe_array_ctrl_pkg;

  // Bits needed to hold n distinct values; never less than one bit.
  function automatic int bw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Instruction word layout.
  localparam int INS_W        = 64;
  localparam int INS_IDX_LSB  = 32;
  localparam int INS_IDX_W    = 8;
  localparam int INS_TRIP_LSB = 40;
  localparam int INS_TRIP_W   = 8;
  localparam int INS_PAD_LSB  = 48;
  localparam int INS_PAD_W    = 4;
  localparam int INS_PEID_LSB = 52;
  localparam int INS_PEID_W   = 6;
  localparam int INS_NEW_BIT  = 58;
  localparam int INS_CUT_BIT  = 59;
  localparam int INS_BAR_BIT  = 60;

  // What happens to the FIFO head in the current cycle.
  typedef enum logic [1:0] {
    DISP_NONE  = 2'd0,  // FIFO empty or flushing
    DISP_DROP  = 2'd1,  // illegal target: pop without start
    DISP_STALL = 2'd2,  // target busy or barrier pending
    DISP_ISSUE = 2'd3   // pop and start the target PEs
  } disp_e;

endpackage

// File: rtl/pe_array_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// ins_fifo
// Synchronous instruction FIFO with flush, occupancy count and registered
// full/empty flags. Writes while full and reads while empty are ignored.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_flush         empty the FIFO at the next edge (push in same cycle lost)
//   i_push, i_data  write request and data
//   i_pop           read request (head advances at the edge)
//   o_head          current head entry
//   o_count         registered occupancy
//   o_full, o_empty registered flags
// ---------------------------------------------------------------------------
module ins_fifo
  import pe_array_ctrl_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int CNT_W = bw(DEPTH + 1),
  localparam int PTR_W = bw(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + CNT_W'(1);
    else if (w_pop && !w_push)
      w_count_nxt = r_count - CNT_W'(1);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush)
      r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/pe_array_ctrl.sv
// ---------------------------------------------------------------------------
// pe_array_ctrl
// Instruction dispatcher for the PE array. Instructions are queued in an
// ins_fifo; the head is decoded into a PE target mask (single PE or a group
// of GRP_SIZE PEs) and issued in order once its targets are idle. Barrier
// instructions additionally wait for the whole array to drain.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   layer_type[0]                    1 = single-PE issue, 0 = group issue
//   ins, ins_valid, ins_ready        instruction stream with backpressure
//   flush                            drop all queued instructions
//   pe_done / pe_start               per-PE completion in / start pulse out
//   idx_cnt, trip_cnt, pad_code,
//   is_new, cut_y                    fields of the last issued instruction
//   busy, all_idle                   per-PE busy state, global idle
//   err_range, err_spurious          sticky error flags
//   issue_cnt                        wrapping count of issued instructions
// ---------------------------------------------------------------------------
module pe_array_ctrl
  import pe_array_ctrl_pkg::*;
#(
  parameter int PE_NUM     = 32,
  parameter int GRP_SIZE   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int INST_W     = INS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            layer_type,
  input  logic [INST_W-1:0]     ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  input  logic                  flush,
  input  logic [PE_NUM-1:0]     pe_done,
  output logic [PE_NUM-1:0]     pe_start,
  output logic [INS_IDX_W-1:0]  idx_cnt,
  output logic [INS_TRIP_W-1:0] trip_cnt,
  output logic [INS_PAD_W-1:0]  pad_code,
  output logic                  is_new,
  output logic                  cut_y,
  output logic [PE_NUM-1:0]     busy,
  output logic                  all_idle,
  output logic                  err_range,
  output logic                  err_spurious,
  output logic [31:0]           issue_cnt
);

  localparam int CNT_W = bw(FIFO_DEPTH + 1);
  localparam int N_GRP = PE_NUM / GRP_SIZE;
  localparam logic [PE_NUM-1:0] GRP_ONES = PE_NUM'((64'd1 << GRP_SIZE) - 64'd1);

  logic [INST_W-1:0]     w_head;
  logic [CNT_W-1:0]      w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  logic [INS_PEID_W-1:0] w_pe_id;
  logic                  w_barrier;
  logic                  w_legal;
  logic [PE_NUM-1:0]     w_mask;
  logic [PE_NUM-1:0]     w_issue_mask;
  disp_e                 w_disp;

  logic [PE_NUM-1:0]     r_pe_start;
  logic [PE_NUM-1:0]     r_busy;
  logic [INS_IDX_W-1:0]  r_idx_cnt;
  logic [INS_TRIP_W-1:0] r_trip_cnt;
  logic [INS_PAD_W-1:0]  r_pad_code;
  logic                  r_is_new;
  logic                  r_cut_y;
  logic                  r_all_idle;
  logic                  r_err_range;
  logic                  r_err_spurious;
  logic [31:0]           r_issue_cnt;

  // Held low during reset so the decoder never sees a stale ready.
  assign ins_ready = ~rst & ~w_full;
  assign w_push    = ins_valid & ins_ready;

  ins_fifo #(
    .WIDTH (INST_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  (ins),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pe_id   = w_head[INS_PEID_LSB +: INS_PEID_W];
  assign w_barrier = w_head[INS_BAR_BIT];

  // Target mask of the head; shifts past the array width yield zero, and
  // an illegal target is forced to an empty mask.
  always_comb begin
    w_mask  = '0;
    w_legal = 1'b0;
    if (layer_type[0]) begin
      w_legal = (32'(w_pe_id) < PE_NUM);
      w_mask  = PE_NUM'(1) << w_pe_id;
    end else begin
      w_legal = (32'(w_pe_id) < N_GRP);
      w_mask  = GRP_ONES << (32'(w_pe_id) * GRP_SIZE);
    end
    if (!w_legal) w_mask = '0;
  end

  // Busy checks use the registered busy vector, so a done pulse in the
  // current cycle never unblocks the head until the following cycle.
  always_comb begin
    w_disp = DISP_NONE;
    if (!w_empty && !flush) begin
      if (!w_legal)
        w_disp = DISP_DROP;
      else if (w_barrier && ((r_busy != '0) || (pe_done != '0)))
        w_disp = DISP_STALL;
      else if ((w_mask & r_busy) != '0)
        w_disp = DISP_STALL;
      else
        w_disp = DISP_ISSUE;
    end
  end

  assign w_pop        = (w_disp == DISP_DROP) || (w_disp == DISP_ISSUE);
  assign w_issue_mask = (w_disp == DISP_ISSUE) ? w_mask : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pe_start     <= '0;
      r_busy         <= '0;
      r_idx_cnt      <= '0;
      r_trip_cnt     <= '0;
      r_pad_code     <= '0;
      r_is_new       <= 1'b0;
      r_cut_y        <= 1'b0;
      r_all_idle     <= 1'b1;
      r_err_range    <= 1'b0;
      r_err_spurious <= 1'b0;
      r_issue_cnt    <= '0;
    end else begin
      r_pe_start <= w_issue_mask;
      r_busy     <= (r_busy & ~pe_done) | w_issue_mask;
      r_all_idle <= (w_count == '0) && (r_busy == '0);
      if (w_disp == DISP_DROP)
        r_err_range <= 1'b1;
      if ((pe_done & ~r_busy) != '0)
        r_err_spurious <= 1'b1;
      if (w_disp == DISP_ISSUE) begin
        r_issue_cnt <= r_issue_cnt + 32'd1;
        r_idx_cnt   <= w_head[INS_IDX_LSB +: INS_IDX_W];
        r_trip_cnt  <= w_head[INS_TRIP_LSB +: INS_TRIP_W];
        r_pad_code  <= w_head[INS_PAD_LSB +: INS_PAD_W];
        r_is_new    <= w_head[INS_NEW_BIT];
        r_cut_y     <= w_head[INS_CUT_BIT];
      end
    end
  end

  assign pe_start     = r_pe_start;
  assign busy         = r_busy;
  assign idx_cnt      = r_idx_cnt;
  assign trip_cnt     = r_trip_cnt;
  assign pad_code     = r_pad_code;
  assign is_new       = r_is_new;
  assign cut_y        = r_cut_y;
  assign all_idle     = r_all_idle;
  assign err_range    = r_err_range;
  assign err_spurious = r_err_spurious;
  assign issue_cnt    = r_issue_cnt;

  // Instruction bits outside the decoded fields and the upper layer_type
  // bits are intentionally ignored.
  logic w_unused;
  assign w_unused = ^{layer_type[3:1], w_head[INS_IDX_LSB-1:0], w_head[INST_W-1:INS_BAR_BIT+1]};

endmodule

// File: tb/tb_pe_array_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pe_array_ctrl
// Directed bench for pe_array_ctrl: reset state, single and group issue,
// busy stalls, FIFO backpressure, barrier, range error, spurious done,
// flush and mid-run reset. Inputs change and outputs are sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_pe_array_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  layer_type;
  logic [63:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic        flush;
  logic [31:0] pe_done;
  logic [31:0] pe_start;
  logic [7:0]  idx_cnt;
  logic [7:0]  trip_cnt;
  logic [3:0]  pad_code;
  logic        is_new;
  logic        cut_y;
  logic [31:0] busy;
  logic        all_idle;
  logic        err_range;
  logic        err_spurious;
  logic [31:0] issue_cnt;

  int n_err = 0;
  int n_chk = 0;

  pe_array_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .layer_type   (layer_type),
    .ins          (ins),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .flush        (flush),
    .pe_done      (pe_done),
    .pe_start     (pe_start),
    .idx_cnt      (idx_cnt),
    .trip_cnt     (trip_cnt),
    .pad_code     (pad_code),
    .is_new       (is_new),
    .cut_y        (cut_y),
    .busy         (busy),
    .all_idle     (all_idle),
    .err_range    (err_range),
    .err_spurious (err_spurious),
    .issue_cnt    (issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL sim_time_limit: run did not reach its summary");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [63:0] mk_ins(input int pe, input int idx, input bit bar);
    logic [63:0] w;
    w         = '0;
    w[39:32]  = idx[7:0];
    w[47:40]  = 8'h34;
    w[51:48]  = 4'h9;
    w[57:52]  = pe[5:0];
    w[58]     = 1'b1;
    w[59]     = 1'b1;
    w[60]     = bar;
    return w;
  endfunction

  // Presents one instruction for a single edge; returns one cycle later.
  task automatic push(input logic [63:0] w);
    ins       = w;
    ins_valid = 1'b1;
    check("push_ready", {63'd0, ins_ready}, 64'd1);
    step();
    ins_valid = 1'b0;
  endtask

  int acc;

  initial begin
    rst        = 1'b1;
    layer_type = 4'd1;
    ins        = '0;
    ins_valid  = 1'b0;
    flush      = 1'b0;
    pe_done    = '0;
    step();
    step();
    check("rst_ready_low", {63'd0, ins_ready}, 64'd0);
    rst = 1'b0;
    step();
    check("rst_ready", {63'd0, ins_ready}, 64'd1);
    check("rst_pe_start", {32'd0, pe_start}, 64'd0);
    check("rst_busy", {32'd0, busy}, 64'd0);
    check("rst_issue_cnt", {32'd0, issue_cnt}, 64'd0);
    check("rst_idx", {56'd0, idx_cnt}, 64'd0);
    check("rst_errs", {62'd0, err_range, err_spurious}, 64'd0);
    check("rst_all_idle", {63'd0, all_idle}, 64'd1);

    // Single mode, PE 5.
    layer_type = 4'd1;
    push(mk_ins(5, 8'h12, 1'b0));
    check("t1_lat1", {32'd0, pe_start}, 64'd0);
    step();
    check("t1_start", {32'd0, pe_start}, 64'h20);
    check("t1_idx", {56'd0, idx_cnt}, 64'h12);
    check("t1_trip", {56'd0, trip_cnt}, 64'h34);
    check("t1_pad", {60'd0, pad_code}, 64'h9);
    check("t1_flags", {62'd0, is_new, cut_y}, 64'h3);
    check("t1_busy", {32'd0, busy}, 64'h20);
    check("t1_cnt", {32'd0, issue_cnt}, 64'd1);
    step();
    check("t1_pulse_end", {32'd0, pe_start}, 64'd0);
    pe_done = 32'h20;
    step();
    pe_done = '0;
    check("t1_busy_clr", {32'd0, busy}, 64'd0);
    step();
    step();
    check("t1_idle", {63'd0, all_idle}, 64'd1);
    check("t1_no_spur", {63'd0, err_spurious}, 64'd0);

    // Group mode, group 2 twice; second waits for done.
    layer_type = 4'd0;
    push(mk_ins(2, 1, 1'b0));
    push(mk_ins(2, 2, 1'b0));
    check("t2_start1", {32'd0, pe_start}, 64'h0F00);
    check("t2_idx1", {56'd0, idx_cnt}, 64'h01);
    step();
    check("t2_stall_a", {32'd0, pe_start}, 64'd0);
    step();
    check("t2_stall_b", {32'd0, pe_start}, 64'd0);
    check("t2_busy", {32'd0, busy}, 64'h0F00);
    pe_done = 32'h0F00;
    step();
    pe_done = '0;
    check("t2_no_early", {32'd0, pe_start}, 64'd0);
    check("t2_busy_clr", {32'd0, busy}, 64'd0);
    step();
    check("t2_start2", {32'd0, pe_start}, 64'h0F00);
    check("t2_idx2", {56'd0, idx_cnt}, 64'h02);
    check("t2_cnt", {32'd0, issue_cnt}, 64'd3);
    pe_done = 32'h0F00;
    step();
    pe_done = '0;
    step();

    // Backpressure: six instructions all on PE 0.
    layer_type = 4'd1;
    acc        = 0;
    ins_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ins = mk_ins(0, 8'h40 + acc, 1'b0);
      if (ins_ready) acc++;
      step();
    end
    ins = mk_ins(0, 8'h45, 1'b0);
    check("t3_accepted", 64'(acc), 64'd5);
    check("t3_full", {63'd0, ins_ready}, 64'd0);
    pe_done = 32'h1;
    step();
    pe_done = '0;
    check("t3_ready_hold", {63'd0, ins_ready}, 64'd0);
    check("t3_no_start", {32'd0, pe_start}, 64'd0);
    step();
    check("t3_start", {32'd0, pe_start}, 64'h1);
    check("t3_idx", {56'd0, idx_cnt}, 64'h41);
    check("t3_ready_back", {63'd0, ins_ready}, 64'd1);
    check("t3_cnt_mid", {32'd0, issue_cnt}, 64'd5);
    step();
    ins_valid = 1'b0;
    for (int i = 0; i < 60 && !all_idle; i++) begin
      pe_done = busy[0] ? 32'h1 : 32'h0;
      step();
    end
    pe_done = '0;
    check("t3_drain_done", {63'd0, all_idle}, 64'd1);
    check("t3_cnt_end", {32'd0, issue_cnt}, 64'd9);
    check("t3_idx_end", {56'd0, idx_cnt}, 64'h45);
    check("t3_no_spur", {63'd0, err_spurious}, 64'd0);

    // Barrier on PE 7 behind busy PE 3.
    push(mk_ins(3, 8'h50, 1'b0));
    push(mk_ins(7, 8'h51, 1'b1));
    check("t4_pe3", {32'd0, pe_start}, 64'h08);
    step();
    check("t4_wait_a", {32'd0, pe_start}, 64'd0);
    step();
    check("t4_wait_b", {32'd0, pe_start}, 64'd0);
    pe_done = 32'h08;
    step();
    pe_done = '0;
    check("t4_wait_c", {32'd0, pe_start}, 64'd0);
    check("t4_busy0", {32'd0, busy}, 64'd0);
    step();
    check("t4_pe7", {32'd0, pe_start}, 64'h80);
    check("t4_idx", {56'd0, idx_cnt}, 64'h51);
    check("t4_busy7", {32'd0, busy}, 64'h80);
    pe_done = 32'h80;
    step();
    pe_done = '0;
    step();

    // Group 8 is out of range; group 1 follows normally.
    layer_type = 4'd0;
    push(mk_ins(8, 8'h60, 1'b0));
    check("t5_err_before", {63'd0, err_range}, 64'd0);
    step();
    check("t5_err_range", {63'd0, err_range}, 64'd1);
    check("t5_no_start", {32'd0, pe_start}, 64'd0);
    check("t5_cnt", {32'd0, issue_cnt}, 64'd11);
    push(mk_ins(1, 8'h61, 1'b0));
    step();
    check("t5_grp1", {32'd0, pe_start}, 64'hF0);
    check("t5_idx", {56'd0, idx_cnt}, 64'h61);
    pe_done = 32'hF0;
    step();
    pe_done = '0;
    layer_type = 4'd1;
    push(mk_ins(31, 8'h62, 1'b0));
    step();
    check("t5_pe31", {32'd0, pe_start}, 64'h8000_0000);
    check("t5_cnt2", {32'd0, issue_cnt}, 64'd13);
    pe_done = 32'h8000_0000;
    step();
    pe_done = '0;
    step();

    // Spurious done, then flush three queued instructions.
    check("t6_spur_before", {63'd0, err_spurious}, 64'd0);
    pe_done = 32'h200;
    step();
    pe_done = '0;
    check("t6_spur", {63'd0, err_spurious}, 64'd1);
    check("t6_busy", {32'd0, busy}, 64'd0);
    push(mk_ins(0, 8'h70, 1'b0));
    push(mk_ins(0, 8'h71, 1'b0));
    check("t6_first", {32'd0, pe_start}, 64'h1);
    push(mk_ins(0, 8'h72, 1'b0));
    push(mk_ins(0, 8'h73, 1'b0));
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t6_flush_nostart", {32'd0, pe_start}, 64'd0);
    pe_done = 32'h1;
    step();
    pe_done = '0;
    check("t6_nostart_a", {32'd0, pe_start}, 64'd0);
    step();
    check("t6_nostart_b", {32'd0, pe_start}, 64'd0);
    step();
    check("t6_nostart_c", {32'd0, pe_start}, 64'd0);
    check("t6_idle", {63'd0, all_idle}, 64'd1);
    check("t6_cnt", {32'd0, issue_cnt}, 64'd14);
    check("t6_idx", {56'd0, idx_cnt}, 64'h70);
    check("t6_errs_kept", {62'd0, err_range, err_spurious}, 64'h3);

    // Reset in the middle of a busy PE.
    push(mk_ins(2, 8'h80, 1'b0));
    step();
    check("t7_busy", {32'd0, busy}, 64'h04);
    rst = 1'b1;
    step();
    check("t7_ready_rst", {63'd0, ins_ready}, 64'd0);
    check("t7_busy_clr", {32'd0, busy}, 64'd0);
    check("t7_cnt_clr", {32'd0, issue_cnt}, 64'd0);
    check("t7_errs_clr", {62'd0, err_range, err_spurious}, 64'd0);
    check("t7_idx_clr", {56'd0, idx_cnt}, 64'd0);
    rst = 1'b0;
    step();
    check("t7_ready", {63'd0, ins_ready}, 64'd1);
    pe_done = 32'h04;
    step();
    pe_done = '0;
    check("t7_spur", {63'd0, err_spurious}, 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
